// File: rtl/exc_sequencer.sv
// Exception entry/return sequencer: latches requests, picks the lowest-index source,
// and steps through capture, flush, vector redirect, handler and ERET return.
module exc_sequencer #(
  parameter int              N         = 64,
  parameter int              NSRC      = 4,
  parameter logic [N-1:0]    EXC_VEC   = 64'hD8,
  parameter int              FLUSH_CYC = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] exc_req,
  input  logic [N-1:0]    fetch_pc,
  input  logic            eret,
  output logic [NSRC-1:0] exc_ack,
  output logic [3:0]      estatus,
  output logic            elr_en,
  output logic            flush,
  output logic            vec_sel,
  output logic            eret_sel,
  output logic            in_handler
);

  typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_VECTOR, S_HANDLER, S_RETURN} state_t;

  state_t          state_q, state_d;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] ack_q, ack_d;
  logic [3:0]      win_q, win_d;
  logic [3:0]      estatus_q, estatus_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [3:0]      win_idx;
  logic [NSRC-1:0] clr;

  // Lowest set index wins; scanning downward lets the lowest overwrite.
  always_comb begin
    win_idx = 4'd0;
    for (int i = NSRC - 1; i >= 0; i--)
      if (pending_q[i]) win_idx = 4'(i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      ack_q     <= '0;
      win_q     <= 4'd0;
      estatus_q <= 4'd0;
      cnt_q     <= 4'd0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ack_q     <= ack_d;
      win_q     <= win_d;
      estatus_q <= estatus_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    estatus_d = estatus_q;
    cnt_d     = cnt_q;
    ack_d     = '0;
    clr       = '0;
    case (state_q)
      S_IDLE: begin
        if (|pending_q) begin
          win_d     = win_idx;
          estatus_d = 4'(win_idx + 4'd1);
          cnt_d     = 4'(FLUSH_CYC - 1);
          state_d   = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (cnt_q == 4'd0) state_d = S_VECTOR;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_VECTOR: begin
        if (fetch_pc == EXC_VEC) begin
          ack_d   = NSRC'(1) << win_q;
          clr     = ack_d;
          state_d = S_HANDLER;
        end
      end
      S_HANDLER: begin
        if (eret) state_d = S_RETURN;
      end
      S_RETURN: begin
        estatus_d = 4'd0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Clear lands with the registered ack; a same-cycle re-pulse survives.
    pending_d = (pending_q & ~clr) | exc_req;
  end

  always_comb begin
    exc_ack    = ack_q;
    estatus    = estatus_q;
    elr_en     = (state_q == S_IDLE) && (|pending_q);
    flush      = (state_q == S_FLUSH) || (state_q == S_VECTOR) || (state_q == S_RETURN);
    vec_sel    = (state_q == S_VECTOR);
    eret_sel   = (state_q == S_RETURN);
    in_handler = (state_q == S_HANDLER);
  end

endmodule

// File: tb/tb_exc_sequencer.sv
// Bench for exc_sequencer: directed vector table, hand sequences and random traffic,
// all compared against a cycle-level timeline model of the exception flow.
module tb_exc_sequencer;
  localparam int          N   = 64;
  localparam int          NS  = 4;
  localparam int          FC  = 3;
  localparam logic [63:0] VEC = 64'hD8;

  logic          clk = 1'b0;
  logic          reset, eret;
  logic [NS-1:0] exc_req;
  logic [N-1:0]  fetch_pc;
  logic [NS-1:0] exc_ack;
  logic [3:0]    estatus;
  logic          elr_en, flush, vec_sel, eret_sel, in_handler;

  always #5 clk = ~clk;

  exc_sequencer #(.N(N), .NSRC(NS), .EXC_VEC(VEC), .FLUSH_CYC(FC)) u_dut (
    .clk(clk), .reset(reset), .exc_req(exc_req), .fetch_pc(fetch_pc), .eret(eret),
    .exc_ack(exc_ack), .estatus(estatus), .elr_en(elr_en), .flush(flush),
    .vec_sel(vec_sel), .eret_sel(eret_sel), .in_handler(in_handler)
  );

  int checks = 0;
  int errors = 0;

  // Timeline model: age counts cycles since the accepting IDLE cycle.
  bit       m_busy, m_hand, m_ret;
  int       m_age, m_cur;
  bit [3:0] m_pend, m_ack, m_est;

  function automatic logic [12:0] model_out();
    bit idle;
    idle = !m_busy && !m_hand && !m_ret;
    return {m_ack, m_est, idle && (m_pend != 0), (m_busy && m_age >= 1) || m_ret,
            m_busy && (m_age > FC), m_ret, m_hand};
  endfunction

  function automatic void model_update();
    bit [3:0] clrm;
    bit       found;
    clrm  = '0;
    m_ack = '0;
    if (reset) begin
      m_busy = 0; m_hand = 0; m_ret = 0; m_age = 0; m_cur = 0;
      m_pend = '0; m_est = '0;
      return;
    end
    if (m_ret) begin
      m_ret = 0;
      m_est = 0;
    end else if (m_hand) begin
      if (eret) begin m_hand = 0; m_ret = 1; end
    end else if (m_busy) begin
      if (m_age > FC && fetch_pc == VEC) begin
        m_busy = 0; m_hand = 1;
        m_ack = 4'(1 << m_cur);
        clrm  = m_ack;
      end else if (m_age <= FC) m_age++;
    end else if (m_pend != 0) begin
      found = 0;
      for (int i = 0; i < NS; i++)
        if (m_pend[i] && !found) begin m_cur = i; found = 1; end
      m_est  = 4'(m_cur + 1);
      m_busy = 1;
      m_age  = 1;
    end
    m_pend = (m_pend & ~clrm) | exc_req;
  endfunction

  function automatic logic [12:0] dut_out();
    return {exc_ack, estatus, elr_en, flush, vec_sel, eret_sel, in_handler};
  endfunction

  task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input bit r, input logic [3:0] q, input bit hit, input bit e);
    reset    = r;
    exc_req  = q;
    eret     = e;
    fetch_pc = hit ? VEC : ({$urandom, $urandom} | 64'h1);
    @(posedge clk);
    model_update();
    @(negedge clk);
    chk("model", dut_out(), model_out());
  endtask

  typedef struct {
    bit       rst;
    bit [3:0] req;
    bit       hit;
    bit       er;
    bit [3:0] ack;
    bit [3:0] est;
    bit       elr, fl, vs, es, ih;
  } vec_t;

  vec_t tbl[19];

  initial begin
    // Fields: rst req hit er | ack est elr fl vs es ih (outputs after the edge)
    tbl[0]  = '{1, 4'b0000, 0, 0, 4'b0000, 4'd0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 4'b0100, 0, 0, 4'b0000, 4'd0, 1, 0, 0, 0, 0};
    tbl[2]  = '{0, 4'b0000, 0, 0, 4'b0000, 4'd3, 0, 1, 0, 0, 0};
    tbl[3]  = '{0, 4'b0000, 0, 0, 4'b0000, 4'd3, 0, 1, 0, 0, 0};
    tbl[4]  = '{0, 4'b0000, 0, 0, 4'b0000, 4'd3, 0, 1, 0, 0, 0};
    tbl[5]  = '{0, 4'b0000, 0, 0, 4'b0000, 4'd3, 0, 1, 1, 0, 0};
    tbl[6]  = '{0, 4'b0000, 0, 0, 4'b0000, 4'd3, 0, 1, 1, 0, 0};
    tbl[7]  = '{0, 4'b0000, 1, 0, 4'b0100, 4'd3, 0, 0, 0, 0, 1};
    tbl[8]  = '{0, 4'b0000, 0, 0, 4'b0000, 4'd3, 0, 0, 0, 0, 1};
    tbl[9]  = '{0, 4'b0000, 0, 1, 4'b0000, 4'd3, 0, 1, 0, 1, 0};
    tbl[10] = '{0, 4'b0000, 0, 0, 4'b0000, 4'd0, 0, 0, 0, 0, 0};
    tbl[11] = '{0, 4'b0000, 0, 1, 4'b0000, 4'd0, 0, 0, 0, 0, 0};
    tbl[12] = '{0, 4'b0001, 0, 0, 4'b0000, 4'd0, 1, 0, 0, 0, 0};
    tbl[13] = '{0, 4'b0000, 0, 1, 4'b0000, 4'd1, 0, 1, 0, 0, 0};
    tbl[14] = '{0, 4'b0000, 0, 1, 4'b0000, 4'd1, 0, 1, 0, 0, 0};
    tbl[15] = '{0, 4'b0000, 0, 0, 4'b0000, 4'd1, 0, 1, 0, 0, 0};
    tbl[16] = '{0, 4'b1000, 0, 0, 4'b0000, 4'd1, 0, 1, 1, 0, 0};
    tbl[17] = '{1, 4'b0000, 1, 0, 4'b0000, 4'd0, 0, 0, 0, 0, 0};
    tbl[18] = '{0, 4'b0000, 1, 0, 4'b0000, 4'd0, 0, 0, 0, 0, 0};

    reset = 1'b1; exc_req = '0; eret = 1'b0; fetch_pc = '0;
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].rst, tbl[i].req, tbl[i].hit, tbl[i].er);
      chk($sformatf("vec%0d", i), dut_out(),
          {tbl[i].ack, tbl[i].est, tbl[i].elr, tbl[i].fl, tbl[i].vs, tbl[i].es, tbl[i].ih});
    end

    // Two simultaneous sources: 1 first, 3 after one IDLE cycle.
    step(0, 4'b1010, 0, 0);
    step(0, 4'b0000, 0, 0);
    chk("t2_first_est", 13'(estatus), 13'd2);
    for (int i = 0; i < 3; i++) step(0, 4'b0000, 0, 0);
    step(0, 4'b0000, 1, 0);
    chk("t2_ack1", 13'(exc_ack), 13'b0010);
    step(0, 4'b0000, 0, 1);
    step(0, 4'b0000, 0, 0);
    chk("t2_second_elr", 13'(elr_en), 13'd1);
    step(0, 4'b0000, 0, 0);
    chk("t2_second_est", 13'(estatus), 13'd4);
    for (int i = 0; i < 3; i++) step(0, 4'b0000, 0, 0);
    step(0, 4'b0000, 1, 0);
    chk("t2_ack3", 13'(exc_ack), 13'b1000);

    // Request arriving inside the handler waits for the return.
    step(0, 4'b0001, 0, 0);
    chk("t3_no_elr", 13'(elr_en), 13'd0);
    for (int i = 0; i < 4; i++) step(0, 4'b0000, 0, 0);
    step(0, 4'b0000, 0, 1);
    step(0, 4'b0000, 0, 0);
    chk("t3_elr_after_ret", 13'(elr_en), 13'd1);

    // Fetch held off the vector for a long time, then released.
    for (int i = 0; i < 24; i++) step(0, 4'b0000, 0, 0);
    chk("t6_vec_held", 13'({vec_sel, exc_ack}), 13'b10000);
    step(0, 4'b0000, 1, 0);
    chk("t6_ack", 13'(exc_ack), 13'b0001);
    step(0, 4'b0000, 0, 1);
    step(0, 4'b0000, 0, 0);

    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 199) == 0,
           ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 5) == 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
